hilo_mdu: RTL and testbench
===========================

Name: hilo_mdu

Overview:
- Iterative multiply/divide unit. It is the producer end of the HI/LO register write interface.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and computes a 64-bit result over several cycles.
- Emits a one-cycle write strobe with hi/lo data. The strobe and data connect directly to the HI/LO register's wen/hi_in/lo_in inputs.

Parameters:
- DATA_W, 32, operand and half-result width. Only 32 is supported.
- DIV_CYCLES, 32, number of divider iteration cycles. Must equal DATA_W.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  DATA_W  multiplicand / dividend
- src_b  in  DATA_W  multiplier / divisor
- busy  out  1  operation in flight; pipeline stalls on it
- done  out  1  one-cycle pulse when the result is valid
- hilo_wen  out  2  2'b11 in the done cycle, 2'b00 otherwise
- hi_out  out  DATA_W  product[63:32] / remainder
- lo_out  out  DATA_W  product[31:0] / quotient

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; busy=0, done=0, hilo_wen=2'b00, hi_out=0, lo_out=0.
  - Internal operand, remainder and counter registers are cleared.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE & start & op[1]=0 -> MUL. Operands are latched.
  - IDLE & start & op[1]=1 -> DIV. Absolute values are latched; quotient and remainder signs are recorded; counter=0.
  - MUL -> FIN after 1 cycle. 64-bit product is registered: signed for MULT, unsigned for MULTU.
  - DIV: one restoring shift-subtract step per cycle. After DIV_CYCLES steps -> FIN, with sign correction applied on entry.
  - FIN -> IDLE unconditionally.
- Timing, with start accepted at edge N:
  - MULT/MULTU: done high in cycle N+2.
  - DIV/DIVU: done high in cycle N+DIV_CYCLES+2, i.e. N+34.
  - busy is high from cycle N+1 through the done cycle inclusive.
  - done, hilo_wen=2'b11 and final hi_out/lo_out are all valid in the same cycle (state FIN).
  - hi_out/lo_out hold their value after FIN until the next FIN.
- start while busy=1 is ignored. Earliest back-to-back start is the cycle after done.
- op, src_a and src_b are sampled only at acceptance; later changes have no effect.
- Signed divide rules:
  - Quotient truncates toward zero.
  - Remainder sign equals dividend sign.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero (src_b=0, signed or unsigned):
  - Full divide latency.
  - lo=0xFFFFFFFF, hi=src_a (original, unsigned-interpreted value).
- Zero dividend: lo=0, hi=0, full latency. There is no early termination.
- Reset asserted mid-operation: immediately returns to IDLE. No done is produced and outputs clear.

Optional Feature:
- Macro: HILO_MDU_CANCEL_EN.
- Defined:
  - Adds input port cancel (1 bit, placed after start), driven by pipeline flush/exception.
  - cancel=1 at an edge in MUL or DIV -> IDLE at that edge; no done, no hilo_wen; hi_out/lo_out unchanged.
  - cancel in the FIN cycle has no effect, because the write is already committed.
  - cancel and start in the same IDLE cycle: cancel wins and start is dropped.
- Undefined: cancel port does not exist; operations always run to completion.

Decomposition:
- Package mdu_pkg:
  - Op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU.
  - State enum IDLE/MUL/DIV/FIN.
  - DIV_CYCLES constant.
  - HILO_WEN_BOTH = 2'b11.
- Sub-module div_core: unsigned restoring-divider datapath.
  - Contents: remainder/quotient shift registers, step counter, load/step inputs and a last-step flag.
  - The top level owns the FSM, sign handling, the multiplier and the output registers.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> done at N+2, hi=0xFFFFFFFF, lo=0xFFFFFFFA, hilo_wen=11 for exactly 1 cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done at N+34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); busy high N+1..N+34; start pulses during busy ignored.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100 at N+34. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- resetn low at N+10 of a DIV -> busy=0, done never pulses, hi/lo=0; new DIVU 9/4 afterwards -> lo=2, hi=1.
- With HILO_MDU_CANCEL_EN: cancel at N+5 of DIV -> no done, hi/lo keep prior values; cancel+start together in IDLE -> stays IDLE, busy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int unsigned DIV_CYCLES = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] HILO_WEN_BOTH = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StFin
    } state_e;

endpackage

// File: rtl/hilo_mdu_if.sv
// EX-stage request / HI-LO write bundle of the multiply/divide unit.
// The cancel signal exists only when HILO_MDU_CANCEL_EN is defined.
interface hilo_mdu_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start;
`ifdef HILO_MDU_CANCEL_EN
    logic              cancel;
`endif
    logic [1:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              busy;
    logic              done;
    logic [1:0]        hilo_wen;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

`ifdef HILO_MDU_CANCEL_EN
    modport master (
        output start, cancel, op, src_a, src_b,
        input  busy, done, hilo_wen, hi_out, lo_out
    );
    modport slave (
        input  start, cancel, op, src_a, src_b,
        output busy, done, hilo_wen, hi_out, lo_out
    );
`else
    modport master (
        output start, op, src_a, src_b,
        input  busy, done, hilo_wen, hi_out, lo_out
    );
    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, hilo_wen, hi_out, lo_out
    );
`endif

endinterface

// File: rtl/div_core.sv
// Unsigned restoring divider datapath: one shift-subtract step per step_i cycle.
module div_core
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CYCLES = DIV_CYCLES
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quo_next_o,
    output logic [DATA_W-1:0] rem_next_o,
    output logic              last_o
);
    localparam int unsigned CntW = $clog2(CYCLES);

    logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
    logic [CntW-1:0]   cnt_q;
    logic [DATA_W:0]   partial, diff;

    // quo_q shifts dividend bits out the top while quotient bits enter at the bottom
    always_comb begin
        partial = {rem_q, quo_q[DATA_W-1]};
        diff    = partial - {1'b0, dvs_q};
        if (diff[DATA_W]) begin
            rem_next_o = partial[DATA_W-1:0];
            quo_next_o = {quo_q[DATA_W-2:0], 1'b0};
        end else begin
            rem_next_o = diff[DATA_W-1:0];
            quo_next_o = {quo_q[DATA_W-2:0], 1'b1};
        end
    end

    assign last_o = step_i && (cnt_q == CntW'(CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= '0;
        end else if (step_i) begin
            rem_q <= rem_next_o;
            quo_q <= quo_next_o;
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/hilo_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit driving the HI/LO register write port.
// Optional HILO_MDU_CANCEL_EN adds a flush input that aborts MUL/DIV.
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DIV_CYCLES = mdu_pkg::DIV_CYCLES
) (
    input logic       clk,
    input logic       resetn,
    hilo_mdu_if.slave bus
);
    state_e              state_q;
    logic [DATA_W-1:0]   a_q, b_q, hi_q, lo_q;
    logic                signed_q, quo_neg_q, rem_neg_q, dbz_q, load_q;
    logic                busy_q, done_q;
    logic [1:0]          wen_q;
    logic                cancel, is_div, op_signed;
    logic [2*DATA_W-1:0] a_ext, b_ext, product;
    logic [DATA_W-1:0]   a_abs, b_abs, quo_next, rem_next, quo_fix, rem_fix;
    logic                div_last;

`ifdef HILO_MDU_CANCEL_EN
    assign cancel = bus.cancel;
`else
    assign cancel = 1'b0;
`endif

    assign is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);

    // Sign-extended 64x64 multiply truncated to 64 bits covers both signednesses
    always_comb begin
        a_ext   = {{DATA_W{signed_q & a_q[DATA_W-1]}}, a_q};
        b_ext   = {{DATA_W{signed_q & b_q[DATA_W-1]}}, b_q};
        product = a_ext * b_ext;
        a_abs   = (signed_q && a_q[DATA_W-1]) ? -a_q : a_q;
        b_abs   = (signed_q && b_q[DATA_W-1]) ? -b_q : b_q;
        quo_fix = quo_neg_q ? -quo_next : quo_next;
        rem_fix = rem_neg_q ? -rem_next : rem_next;
    end

    div_core #(
        .DATA_W (DATA_W),
        .CYCLES (DIV_CYCLES)
    ) u_div_core (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     ((state_q == StDiv) && load_q),
        .step_i     ((state_q == StDiv) && !load_q),
        .dividend_i (a_abs),
        .divisor_i  (b_abs),
        .quo_next_o (quo_next),
        .rem_next_o (rem_next),
        .last_o     (div_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            signed_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wen_q     <= 2'b00;
        end else begin
            done_q <= 1'b0;
            wen_q  <= 2'b00;
            unique case (state_q)
                StIdle: begin
                    if (bus.start && !cancel) begin
                        a_q      <= bus.src_a;
                        b_q      <= bus.src_b;
                        signed_q <= op_signed;
                        busy_q   <= 1'b1;
                        if (is_div) begin
                            state_q   <= StDiv;
                            load_q    <= 1'b1;
                            quo_neg_q <= op_signed & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
                            rem_neg_q <= op_signed & bus.src_a[DATA_W-1];
                            dbz_q     <= (bus.src_b == '0);
                        end else begin
                            state_q <= StMul;
                        end
                    end
                end
                StMul: begin
                    if (cancel) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StFin;
                        hi_q    <= product[2*DATA_W-1:DATA_W];
                        lo_q    <= product[DATA_W-1:0];
                        done_q  <= 1'b1;
                        wen_q   <= HILO_WEN_BOTH;
                    end
                end
                StDiv: begin
                    if (cancel) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        load_q <= 1'b0;
                        if (div_last) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                            wen_q   <= HILO_WEN_BOTH;
                            // Divide by zero returns all-ones quotient and the raw dividend
                            hi_q    <= dbz_q ? a_q : rem_fix;
                            lo_q    <= dbz_q ? '1 : quo_fix;
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hilo_wen = wen_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu; cancel checks compile in with HILO_MDU_CANCEL_EN.
module tb_hilo_mdu;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic  clk    = 1'b0;
    logic  resetn = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    exp_t  sb[$];
    exp_t  mon_e;
    vec_t  vecs[$];
    logic [31:0] last_hi, last_lo;

    hilo_mdu_if #(.DATA_W(32)) bus ();

    hilo_mdu #(
        .DATA_W     (32),
        .DIV_CYCLES (32)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest scoreboard entry, on its cycle
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", {63'd0, bus.done}, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("hi_out", {32'd0, bus.hi_out}, {32'd0, mon_e.hi});
                    check("lo_out", {32'd0, bus.lo_out}, {32'd0, mon_e.lo});
                    check("wen_done", {62'd0, bus.hilo_wen}, 64'd3);
                    check("busy_done", {63'd0, bus.busy}, 64'd1);
                end
            end else begin
                check("wen_idle", {62'd0, bus.hilo_wen}, 64'd0);
                if (sb.size() != 0 && cyc > sb[0].cyc) begin
                    check("done_by_cycle", 64'(cyc), 64'(sb[0].cyc));
                    mon_e = sb.pop_front();
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input bit expect_done);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        n = cyc;
        if (expect_done) sb.push_back('{hi: hi, lo: lo, cyc: n + (op[1] ? 33 : 1)});
        // Scramble operands after acceptance; they must not affect the result
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.src_a = ~a;
        bus.src_b = b + 32'd1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.busy && k < 100);
        if (k >= 100) check("idle_timeout", {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
`ifdef HILO_MDU_CANCEL_EN
        bus.cancel = 1'b0;
`endif
        vecs.push_back('{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{OP_MULT,  32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{OP_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF});
        vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{OP_DIVU,  32'd0,         32'd5,         32'd0,         32'd0});
        vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999});

        #12;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_wen", {62'd0, bus.hilo_wen}, 64'd0);
        check("rst_hi", {32'd0, bus.hi_out}, 64'd0);
        check("rst_lo", {32'd0, bus.lo_out}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
            wait_idle();
        end

        // Busy window of a DIV, with a start pulse that must be ignored
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            check("busy_window", {63'd0, bus.busy}, 64'd1);
            if (k == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_MULT;
                bus.src_a = 32'd1;
                bus.src_b = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        wait_idle();
        check("busy_after", {63'd0, bus.busy}, 64'd0);
        repeat (3) @(negedge clk);
        check("hold_hi", {32'd0, bus.hi_out}, 64'hFFFF_FFFF);
        check("hold_lo", {32'd0, bus.lo_out}, 64'hFFFF_FFFD);

        // Reset in the middle of a divide
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_wen", {62'd0, bus.hilo_wen}, 64'd0);
        check("midrst_hi", {32'd0, bus.hi_out}, 64'd0);
        check("midrst_lo", {32'd0, bus.lo_out}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        issue(OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b1);
        wait_idle();
        last_hi = 32'd1;
        last_lo = 32'd2;

`ifdef HILO_MDU_CANCEL_EN
        issue(OP_DIV, 32'd50, 32'd7, 32'd0, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", {63'd0, bus.busy}, 64'd0);
        check("cancel_hi", {32'd0, bus.hi_out}, {32'd0, last_hi});
        check("cancel_lo", {32'd0, bus.lo_out}, {32'd0, last_lo});
        repeat (40) @(negedge clk);
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = OP_DIVU;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("cancel_start_busy", {63'd0, bus.busy}, 64'd0);
        repeat (40) @(negedge clk);
        issue(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
